// File: rtl/mmio_uart_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_uart_ctrl
//
// Memory-mapped I/O controller sitting beside the data memory of the RISC-V
// core. It decodes EX-stage loads/stores that land in a 32-byte window at
// MMIO_BASE, buffers bytes coming from the UART receiver in a small FIFO,
// holds one byte for the UART transmitter, and keeps the cycle (CC) and
// retired-instruction (IC) counters. Load data is registered so it shows up
// in MEM/WB at the same time as data-memory read data.
//
// Register map (word offsets from MMIO_BASE):
//   0x00 CTRL  R   {30'b0, rx_nonempty, tx_empty}
//   0x04 RX    R   {24'b0, FIFO head}; pops the FIFO when non-empty
//   0x08 TX    W   loads the transmit holding register when it is empty
//   0x10 CC    R   cycle counter
//   0x14 IC    R   retired-instruction counter
//   0x18 RST   W   clears CC and IC
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   req_valid      EX-stage memory access this cycle
//   req_we         1 = store, 0 = load
//   req_addr       byte address of the access
//   req_wdata      store data (low byte)
//   inst_retire    one instruction retired this cycle
//   mmio_hit       access targets a defined MMIO register (combinational)
//   rd_sel         registered: previous load was an MMIO hit
//   rd_data        registered MMIO read data
//   uart_rx_data   byte from the UART receiver
//   uart_rx_valid  receiver offers a byte
//   uart_rx_ready  FIFO can accept a byte
//   uart_tx_data   byte for the UART transmitter
//   uart_tx_valid  a transmit byte is held
//   uart_tx_ready  transmitter accepts the held byte
// ---------------------------------------------------------------------------
module mmio_uart_ctrl #(
    parameter int          RX_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        inst_retire,
    output logic        mmio_hit,
    output logic        rd_sel,
    output logic [31:0] rd_data,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int PTR_W = $clog2(RX_DEPTH);

    localparam logic [4:0] OFF_CTRL = 5'h00;
    localparam logic [4:0] OFF_RX   = 5'h04;
    localparam logic [4:0] OFF_TX   = 5'h08;
    localparam logic [4:0] OFF_CC   = 5'h10;
    localparam logic [4:0] OFF_IC   = 5'h14;
    localparam logic [4:0] OFF_RST  = 5'h18;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    logic       in_window;
    logic [4:0] offset;
    logic       sel_ctrl;
    logic       sel_rx;
    logic       sel_tx;
    logic       sel_cc;
    logic       sel_ic;
    logic       sel_rst;

    assign in_window = (req_addr[31:5] == MMIO_BASE[31:5]);
    assign offset    = req_addr[4:0];

    // Only exact word offsets of defined registers count as hits; misaligned
    // or unused offsets inside the window fall through to no effect.
    always_comb begin
        sel_ctrl = 1'b0;
        sel_rx   = 1'b0;
        sel_tx   = 1'b0;
        sel_cc   = 1'b0;
        sel_ic   = 1'b0;
        sel_rst  = 1'b0;
        if (req_valid && in_window) begin
            case (offset)
                OFF_CTRL: sel_ctrl = 1'b1;
                OFF_RX:   sel_rx   = 1'b1;
                OFF_TX:   sel_tx   = 1'b1;
                OFF_CC:   sel_cc   = 1'b1;
                OFF_IC:   sel_ic   = 1'b1;
                OFF_RST:  sel_rst  = 1'b1;
                default:  ;
            endcase
        end
    end

    assign mmio_hit = sel_ctrl | sel_rx | sel_tx | sel_cc | sel_ic | sel_rst;

    logic load_hit;
    logic rx_read;
    logic tx_write;
    logic cnt_clear;

    // Loads of write-only registers and stores to read-only registers still
    // hit (so DMEM is left alone) but produce no side effects.
    assign load_hit  = mmio_hit && !req_we;
    assign rx_read   = sel_rx  && !req_we;
    assign tx_write  = sel_tx  &&  req_we;
    assign cnt_clear = sel_rst &&  req_we;

    // -----------------------------------------------------------------------
    // Receive FIFO
    // -----------------------------------------------------------------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic [PTR_W:0] rx_count;
    logic           rx_full;
    logic           rx_empty;
    logic           rx_push;
    logic           rx_pop;
    logic [7:0]     rx_head;

    // The extra pointer bit distinguishes full from empty when the index
    // bits are equal; the difference is the occupancy 0..RX_DEPTH.
    assign rx_count      = wr_ptr - rd_ptr;
    assign rx_empty      = (wr_ptr == rd_ptr);
    assign rx_full       = (rx_count == (PTR_W + 1)'(RX_DEPTH));
    assign uart_rx_ready = !rx_full;
    assign rx_push       = uart_rx_valid && !rx_full;
    assign rx_head       = rx_mem[rd_ptr[PTR_W-1:0]];

    // A read of an empty FIFO returns 0 and does not pop, even if a byte is
    // being pushed in the same cycle; that byte is left for the next read.
    assign rx_pop = rx_read && !rx_empty;

    // Pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr[PTR_W-1:0]] <= uart_rx_data;
        end
    end

    // -----------------------------------------------------------------------
    // Transmit holding register
    // -----------------------------------------------------------------------
    // A handshake takes precedence: a TX write in the same cycle sees the
    // register as full and is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (uart_tx_valid && uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
        end else if (tx_write && !uart_tx_valid) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= req_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
    logic [31:0] cycle_count;
    logic [31:0] inst_count;

    // Clear wins over increment so CC reads 0 in the cycle after the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= 32'd0;
            inst_count  <= 32'd0;
        end else if (cnt_clear) begin
            cycle_count <= 32'd0;
            inst_count  <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            inst_count  <= inst_count + {31'd0, inst_retire};
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [31:0] read_value;

    // All values are taken before this cycle's updates land.
    always_comb begin
        read_value = 32'd0;
        if (sel_ctrl) begin
            read_value = {30'd0, !rx_empty, !uart_tx_valid};
        end else if (sel_rx) begin
            read_value = rx_empty ? 32'd0 : {24'd0, rx_head};
        end else if (sel_cc) begin
            read_value = cycle_count;
        end else if (sel_ic) begin
            read_value = inst_count;
        end
    end

    // Read results hold until the next memory access so WB can pick them up
    // regardless of pipeline bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel  <= 1'b0;
            rd_data <= 32'd0;
        end else if (req_valid) begin
            rd_sel  <= load_hit;
            rd_data <= load_hit ? read_value : 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mmio_uart_ctrl
//
// Self-checking bench for mmio_uart_ctrl. Stimulus tasks issue accesses one
// cycle at a time; every load pushes its expected response into a queue and
// a monitor pops and compares when the registered result appears.
// ---------------------------------------------------------------------------
module tb_mmio_uart_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_wdata;
    logic        inst_retire;
    logic        mmio_hit;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    mmio_uart_ctrl #(
        .RX_DEPTH  (4),
        .MMIO_BASE (BASE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .inst_retire   (inst_retire),
        .mmio_hit      (mmio_hit),
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        sel;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic load_issued = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Remember whether the access sampled on this edge was a load.
    always @(posedge clk) begin
        load_issued <= req_valid && !req_we && rst;
    end

    // Scoreboard monitor: compare registered read results half a cycle later.
    always @(negedge clk) begin
        if (load_issued) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: load result with no expected entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_output({e.name, ".rd_sel"}, {31'd0, rd_sel}, {31'd0, e.sel});
                if (e.sel) begin
                    check_output({e.name, ".rd_data"}, rd_data, e.data);
                end
            end
        end
    end

    // Advance to the next cycle and drop the per-cycle inputs back to idle.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 8'd0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'd0;
        inst_retire   = 1'b0;
    endtask

    task automatic issue_load(input string name, input logic [31:0] addr,
                              input logic sel, input logic [31:0] data);
        exp_t e;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        e.name    = name;
        e.sel     = sel;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    task automatic issue_store(input logic [31:0] addr, input logic [7:0] data);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
    endtask

    task automatic push_rx(input logic [7:0] data);
        uart_rx_valid = 1'b1;
        uart_rx_data  = data;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] rx_bytes [4];
        rx_bytes = '{8'h41, 8'h42, 8'h43, 8'h44};

        rst           = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = 32'd0;
        req_wdata     = 8'd0;
        inst_retire   = 1'b0;
        uart_rx_data  = 8'd0;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("reset.rd_data", rd_data, 32'd0);
        check_output("reset.rd_sel", {31'd0, rd_sel}, 32'd0);
        check_output("reset.rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        check_output("reset.tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check_output("reset.tx_data", {24'd0, uart_tx_data}, 32'd0);
        #3 rst = 1'b1;

        apply_stimulus();
        issue_load("ctrl_after_reset", BASE + 32'h00, 1'b1, 32'h0000_0001);

        // Fill the RX FIFO and try a fifth byte
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            push_rx(rx_bytes[i]);
        end
        apply_stimulus();
        #1 check_output("rx_full.rx_ready", {31'd0, uart_rx_ready}, 32'd0);
        push_rx(8'h55);
        issue_load("ctrl_rx_full", BASE + 32'h00, 1'b1, 32'h0000_0003);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            issue_load("rx_pop", BASE + 32'h04, 1'b1, {24'd0, rx_bytes[i]});
        end
        apply_stimulus();
        issue_load("rx_empty_read", BASE + 32'h04, 1'b1, 32'd0);
        apply_stimulus();
        issue_load("ctrl_rx_drained", BASE + 32'h00, 1'b1, 32'h0000_0001);

        // TX holding register
        apply_stimulus();
        issue_store(BASE + 32'h08, 8'h5A);
        #1 check_output("tx_store.mmio_hit", {31'd0, mmio_hit}, 32'd1);
        apply_stimulus();
        #1 check_output("tx_load.valid", {31'd0, uart_tx_valid}, 32'd1);
        check_output("tx_load.data", {24'd0, uart_tx_data}, 32'h5A);
        issue_store(BASE + 32'h08, 8'h33);
        apply_stimulus();
        #1 check_output("tx_drop.data", {24'd0, uart_tx_data}, 32'h5A);
        issue_load("ctrl_tx_full", BASE + 32'h00, 1'b1, 32'h0000_0000);
        uart_tx_ready = 1'b1;
        apply_stimulus();
        uart_tx_ready = 1'b0;
        #1 check_output("tx_done.valid", {31'd0, uart_tx_valid}, 32'd0);
        issue_load("ctrl_tx_empty", BASE + 32'h00, 1'b1, 32'h0000_0001);

        // Instruction counter
        apply_stimulus();
        issue_store(BASE + 32'h18, 8'h00);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus();
            inst_retire = (i % 2 == 0);
        end
        apply_stimulus();
        issue_load("ic_ten", BASE + 32'h14, 1'b1, 32'd10);
        apply_stimulus();
        issue_store(BASE + 32'h18, 8'hFF);
        inst_retire = 1'b1;
        apply_stimulus();
        issue_load("ic_cleared", BASE + 32'h14, 1'b1, 32'd0);

        // Cycle counter after clear
        apply_stimulus();
        issue_store(BASE + 32'h18, 8'h01);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            issue_load("cc_count", BASE + 32'h10, 1'b1, i);
        end

        // Undefined and write-only addresses
        apply_stimulus();
        issue_load("undef_0c", BASE + 32'h0C, 1'b0, 32'd0);
        #1 check_output("undef_0c.mmio_hit", {31'd0, mmio_hit}, 32'd0);
        apply_stimulus();
        issue_load("out_of_window", 32'h8000_0024, 1'b0, 32'd0);
        #1 check_output("out_of_window.mmio_hit", {31'd0, mmio_hit}, 32'd0);
        apply_stimulus();
        issue_load("load_tx_wo", BASE + 32'h08, 1'b1, 32'd0);
        #1 check_output("load_tx_wo.mmio_hit", {31'd0, mmio_hit}, 32'd1);

        // Simultaneous push and pop with two bytes buffered
        apply_stimulus();
        push_rx(8'h61);
        apply_stimulus();
        push_rx(8'h62);
        apply_stimulus();
        push_rx(8'h63);
        issue_load("pushpop_first", BASE + 32'h04, 1'b1, 32'h61);
        apply_stimulus();
        issue_load("pushpop_second", BASE + 32'h04, 1'b1, 32'h62);
        apply_stimulus();
        issue_load("pushpop_third", BASE + 32'h04, 1'b1, 32'h63);
        apply_stimulus();
        issue_load("pushpop_empty", BASE + 32'h04, 1'b1, 32'd0);

        // Push into an empty FIFO while RX is read
        apply_stimulus();
        push_rx(8'h77);
        issue_load("empty_push_read", BASE + 32'h04, 1'b1, 32'd0);
        apply_stimulus();
        issue_load("empty_push_later", BASE + 32'h04, 1'b1, 32'h77);

        // Reset in the middle of a pending TX with RX data buffered
        apply_stimulus();
        issue_store(BASE + 32'h08, 8'hA5);
        push_rx(8'h99);
        apply_stimulus();
        apply_stimulus();
        #1 check_output("pre_reset.tx_valid", {31'd0, uart_tx_valid}, 32'd1);
        #1 rst = 1'b0;
        #1 check_output("async_reset.tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check_output("async_reset.tx_data", {24'd0, uart_tx_data}, 32'd0);
        check_output("async_reset.rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        #1 rst = 1'b1;
        apply_stimulus();
        issue_load("ctrl_after_async_reset", BASE + 32'h00, 1'b1, 32'h0000_0001);
        apply_stimulus();
        apply_stimulus();

        check_output("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
